// File: rtl/gps_sig_gen.sv
// gps_sig_gen: synthetic GPS L1 C/A 1-bit I/Q baseband source.
// Generates the C/A code of a selected PRN at a programmable start chip, code
// rate and carrier offset, on an adc_clk strobe every SAMPLE_DIV clocks.
// Optional build macro NAV_DATA_EN adds nav_bit/nav_req and XORs a 20-epoch
// navigation data bit into the code; without it the data bit is constant 0.
module gps_sig_gen #(
  parameter int unsigned SAMPLE_DIV = 2,
  parameter int unsigned ACC_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             gen_start,
  input  logic             gen_stop,
  input  logic [4:0]       sat,
  input  logic [9:0]       init_chip,
  input  logic [ACC_W-1:0] code_fcw,
  input  logic [ACC_W-1:0] carr_fcw,
  input  logic [15:0]      n_epochs,
`ifdef NAV_DATA_EN
  input  logic             nav_bit,
  output logic             nav_req,
`endif
  output logic             adc_clk,
  output logic             i_sample,
  output logic             q_sample,
  output logic             epoch,
  output logic [9:0]       chip_idx,
  output logic             busy,
  output logic             start_err
);

  localparam logic [7:0] DIV_LAST  = 8'(SAMPLE_DIV - 1);
  localparam logic [9:0] LAST_CHIP = 10'd1022;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

  state_t           state_q;
  logic [4:0]       sat_q;
  logic [9:0]       init_q;
  logic [ACC_W-1:0] code_fcw_q;
  logic [ACC_W-1:0] carr_fcw_q;
  logic [15:0]      n_ep_q;
  logic [10:1]      g1_q, g2_q;
  logic [9:0]       chip_q;
  logic [ACC_W-1:0] code_acc_q;
  logic [ACC_W-1:0] carr_acc_q;
  logic [7:0]       div_q;
  logic [15:0]      ep_cnt_q;
  logic             done_q;
  logic             adc_q, i_q, q_q, epoch_q, busy_q, start_err_q;

  logic [10:1]      g1_d, g2_d;
  logic [ACC_W-1:0] code_acc_d;
  logic             code_cy;
  logic [3:0]       tap_a, tap_b;
  logic             chip_c, i_d, q_d;
  logic [9:0]       init_clamp;
  logic             nav_data;

`ifdef NAV_DATA_EN
  logic [4:0]       nav_cnt_q;
  logic             nav_data_q;
  logic             nav_req_q;
  assign nav_data = nav_data_q;
  assign nav_req  = nav_req_q;
`else
  assign nav_data = 1'b0;
`endif

  assign adc_clk   = adc_q;
  assign i_sample  = i_q;
  assign q_sample  = q_q;
  assign epoch     = epoch_q;
  assign chip_idx  = chip_q;
  assign busy      = busy_q;
  assign start_err = start_err_q;

  // G2 phase-selector tap pair for the latched PRN
  always_comb begin
    tap_a = 4'd2;
    tap_b = 4'd6;
    case (sat_q)
      5'd1:  begin tap_a = 4'd2; tap_b = 4'd6;  end
      5'd2:  begin tap_a = 4'd3; tap_b = 4'd7;  end
      5'd3:  begin tap_a = 4'd4; tap_b = 4'd8;  end
      5'd4:  begin tap_a = 4'd5; tap_b = 4'd9;  end
      5'd5:  begin tap_a = 4'd1; tap_b = 4'd9;  end
      5'd6:  begin tap_a = 4'd2; tap_b = 4'd10; end
      5'd7:  begin tap_a = 4'd1; tap_b = 4'd8;  end
      5'd8:  begin tap_a = 4'd2; tap_b = 4'd9;  end
      5'd9:  begin tap_a = 4'd3; tap_b = 4'd10; end
      5'd10: begin tap_a = 4'd2; tap_b = 4'd3;  end
      5'd11: begin tap_a = 4'd3; tap_b = 4'd4;  end
      5'd12: begin tap_a = 4'd5; tap_b = 4'd6;  end
      5'd13: begin tap_a = 4'd6; tap_b = 4'd7;  end
      5'd14: begin tap_a = 4'd7; tap_b = 4'd8;  end
      5'd15: begin tap_a = 4'd8; tap_b = 4'd9;  end
      5'd16: begin tap_a = 4'd9; tap_b = 4'd10; end
      5'd17: begin tap_a = 4'd1; tap_b = 4'd4;  end
      5'd18: begin tap_a = 4'd2; tap_b = 4'd5;  end
      5'd19: begin tap_a = 4'd3; tap_b = 4'd6;  end
      5'd20: begin tap_a = 4'd4; tap_b = 4'd7;  end
      5'd21: begin tap_a = 4'd5; tap_b = 4'd8;  end
      5'd22: begin tap_a = 4'd6; tap_b = 4'd9;  end
      5'd23: begin tap_a = 4'd1; tap_b = 4'd3;  end
      5'd24: begin tap_a = 4'd4; tap_b = 4'd6;  end
      5'd25: begin tap_a = 4'd5; tap_b = 4'd7;  end
      5'd26: begin tap_a = 4'd6; tap_b = 4'd8;  end
      5'd27: begin tap_a = 4'd7; tap_b = 4'd9;  end
      5'd28: begin tap_a = 4'd8; tap_b = 4'd10; end
      5'd29: begin tap_a = 4'd1; tap_b = 4'd6;  end
      5'd30: begin tap_a = 4'd2; tap_b = 4'd7;  end
      5'd31: begin tap_a = 4'd3; tap_b = 4'd8;  end
      default: begin tap_a = 4'd2; tap_b = 4'd6; end
    endcase
  end

  // Next LFSR states, code NCO sum/carry, chip and carrier-mixed samples
  always_comb begin
    g1_d = {g1_q[9:1], g1_q[3] ^ g1_q[10]};
    g2_d = {g2_q[9:1], g2_q[2] ^ g2_q[3] ^ g2_q[6] ^ g2_q[8] ^ g2_q[9] ^ g2_q[10]};
    {code_cy, code_acc_d} = {1'b0, code_acc_q} + {1'b0, code_fcw_q};
    chip_c = g1_q[10] ^ g2_q[tap_a] ^ g2_q[tap_b] ^ nav_data;
    i_d    = chip_c ^ carr_acc_q[ACC_W-1] ^ carr_acc_q[ACC_W-2];
    q_d    = chip_c ^ carr_acc_q[ACC_W-1];
    init_clamp = (init_chip > LAST_CHIP) ? LAST_CHIP : init_chip;
  end

  // Control FSM with registered outputs, LFSRs, NCOs and epoch counting
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      sat_q       <= '0;
      init_q      <= '0;
      code_fcw_q  <= '0;
      carr_fcw_q  <= '0;
      n_ep_q      <= '0;
      g1_q        <= '1;
      g2_q        <= '1;
      chip_q      <= '0;
      code_acc_q  <= '0;
      carr_acc_q  <= '0;
      div_q       <= '0;
      ep_cnt_q    <= '0;
      done_q      <= 1'b0;
      adc_q       <= 1'b0;
      i_q         <= 1'b0;
      q_q         <= 1'b0;
      epoch_q     <= 1'b0;
      busy_q      <= 1'b0;
      start_err_q <= 1'b0;
`ifdef NAV_DATA_EN
      nav_cnt_q   <= '0;
      nav_data_q  <= 1'b0;
      nav_req_q   <= 1'b0;
`endif
    end else begin
      adc_q       <= 1'b0;
      epoch_q     <= 1'b0;
      start_err_q <= 1'b0;
`ifdef NAV_DATA_EN
      nav_req_q   <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (gen_start && !gen_stop) begin
            if (sat != 5'd0) begin
              sat_q      <= sat;
              init_q     <= init_clamp;
              code_fcw_q <= code_fcw;
              carr_fcw_q <= carr_fcw;
              n_ep_q     <= n_epochs;
              g1_q       <= '1;
              g2_q       <= '1;
              chip_q     <= '0;
              code_acc_q <= '0;
              carr_acc_q <= '0;
              div_q      <= '0;
              ep_cnt_q   <= '0;
              done_q     <= 1'b0;
              busy_q     <= 1'b1;
              state_q    <= S_LOAD;
`ifdef NAV_DATA_EN
              nav_cnt_q  <= '0;
              nav_data_q <= 1'b0;
`endif
            end else begin
              start_err_q <= 1'b1;
            end
          end
        end
        default: begin
          start_err_q <= gen_start;
          // An explicit stop and completion of the requested epochs share one exit path.
          if (gen_stop || done_q) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            i_q     <= 1'b0;
            q_q     <= 1'b0;
            chip_q  <= '0;
            done_q  <= 1'b0;
          end else if (state_q == S_LOAD) begin
            if (chip_q == init_q) begin
              state_q <= S_RUN;
              div_q   <= '0;
            end else begin
              g1_q   <= g1_d;
              g2_q   <= g2_d;
              chip_q <= chip_q + 10'd1;
            end
          end else if (div_q == DIV_LAST) begin
            div_q      <= '0;
            adc_q      <= 1'b1;
            i_q        <= i_d;
            q_q        <= q_d;
            carr_acc_q <= carr_acc_q + carr_fcw_q;
            code_acc_q <= code_acc_d;
            if (code_cy) begin
              if (chip_q == LAST_CHIP) begin
                chip_q  <= '0;
                g1_q    <= '1;
                g2_q    <= '1;
                epoch_q <= 1'b1;
                if (n_ep_q != 16'd0) begin
                  ep_cnt_q <= ep_cnt_q + 16'd1;
                  if (ep_cnt_q + 16'd1 == n_ep_q) done_q <= 1'b1;
                end
`ifdef NAV_DATA_EN
                if (nav_cnt_q == 5'd19) begin
                  nav_cnt_q  <= '0;
                  nav_req_q  <= 1'b1;
                  nav_data_q <= nav_bit;
                end else begin
                  nav_cnt_q  <= nav_cnt_q + 5'd1;
                end
`endif
              end else begin
                g1_q   <= g1_d;
                g2_q   <= g2_d;
                chip_q <= chip_q + 10'd1;
              end
            end
          end else begin
            div_q <= div_q + 8'd1;
          end
        end
      endcase
    end
  end

endmodule
